sys_rst_seq: RTL and testbench

SYS_RST_SEQ -- requirements
Module: sys_rst_seq

---
 rtl/sys_rst_seq_pkg.sv | 19 +
 rtl/sys_sync_2ff.sv | 29 ++
 rtl/sys_rst_seq.sv | 211 +++++++++++++++++++++
 tb/tb_sys_rst_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_rst_seq_pkg.sv
// Shared state encoding and counter sizing for the reset sequencer.
package sys_rst_seq_pkg;

  localparam int NUM_CH_MAX = 16;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_HOLD      = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_e;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sys_sync_2ff.sv
// Single-bit two-flop synchroniser; both flops clear to 0 on reset.
module sys_sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sys_rst_seq.sv
// PLL reset / lock filter / staggered channel release sequencer.
// Define SYS_RST_SEQ_TIMEOUT_EN to add the sticky lock timeout (timeout_o).
module sys_rst_seq #(
  parameter int NUM_CH       = 4,
  parameter int PLL_RST_CNT  = 8,
  parameter int LOCK_FILTER  = 16,
  parameter int HOLD_CNT     = 50,
  parameter int STAGGER_CNT  = 10,
  parameter int LOCK_TIMEOUT = 1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ext_rst_n_i,
  input  logic              pll_locked_i,
  input  logic              sw_rst_i,
  output logic              pll_rst_o,
  output logic [NUM_CH-1:0] ch_rst_n_o,
  output logic              seq_done_o,
  output logic              timeout_o
);

  import sys_rst_seq_pkg::*;

  if (NUM_CH < 1 || NUM_CH > NUM_CH_MAX || PLL_RST_CNT < 1 || LOCK_FILTER < 1 ||
      HOLD_CNT < 0 || STAGGER_CNT < 1 || LOCK_TIMEOUT < 1) begin : g_param_err
    $error("sys_rst_seq: parameter out of range");
  end

  localparam int PLL_W  = cnt_w(PLL_RST_CNT);
  localparam int FILT_W = cnt_w(LOCK_FILTER);
  localparam int HOLD_W = cnt_w(HOLD_CNT);
  localparam int STG_W  = cnt_w(STAGGER_CNT);

  localparam logic [PLL_W-1:0]  PLL_LAST  = PLL_W'(PLL_RST_CNT - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CNT > 0) ? HOLD_CNT - 1 : 0);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER_CNT - 1);
  localparam logic [NUM_CH-1:0] CH_FIRST  = NUM_CH'(1);

  logic ext_rst_n_sync;
  logic lock_sync;

  sys_sync_2ff u_sync_ext (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (ext_rst_n_i),
    .q_o   (ext_rst_n_sync)
  );

  sys_sync_2ff u_sync_lock (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pll_locked_i),
    .q_o   (lock_sync)
  );

  state_e            state_q, state_d;
  logic [PLL_W-1:0]  pll_cnt_q, pll_cnt_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [STG_W-1:0]  stg_cnt_q, stg_cnt_d;
  logic              pll_rst_q, pll_rst_d;
  logic [NUM_CH-1:0] ch_rst_n_q, ch_rst_n_d;
  logic              seq_done_q, seq_done_d;

`ifdef SYS_RST_SEQ_TIMEOUT_EN
  localparam int                TO_W    = cnt_w(LOCK_TIMEOUT);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  always_comb begin
    state_d    = state_q;
    pll_cnt_d  = '0;
    filt_cnt_d = '0;
    hold_cnt_d = '0;
    stg_cnt_d  = '0;
    ch_rst_n_d = ch_rst_n_q;
    seq_done_d = 1'b0;
`ifdef SYS_RST_SEQ_TIMEOUT_EN
    to_cnt_d   = '0;
    timeout_d  = timeout_q;
`endif

    case (state_q)
      S_PLL_RST: begin
        ch_rst_n_d = '0;
        if (pll_cnt_q == PLL_LAST) state_d = S_WAIT_LOCK;
        else                       pll_cnt_d = pll_cnt_q + 1'b1;
      end
      S_WAIT_LOCK: begin
        ch_rst_n_d = '0;
        if (lock_sync && filt_cnt_q == FILT_LAST) begin
          if (HOLD_CNT == 0) begin
            state_d    = S_RELEASE;
            ch_rst_n_d = CH_FIRST;
          end else begin
            state_d = S_HOLD;
          end
        end else begin
          if (lock_sync) filt_cnt_d = filt_cnt_q + 1'b1;
`ifdef SYS_RST_SEQ_TIMEOUT_EN
          if (to_cnt_q == TO_LAST) begin
            state_d    = S_PLL_RST;
            timeout_d  = 1'b1;
            filt_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
`endif
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = S_RELEASE;
          ch_rst_n_d = CH_FIRST;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        // Top channel already released: one more cycle, then run.
        if (ch_rst_n_q[NUM_CH-1]) begin
          state_d    = S_RUN;
          seq_done_d = 1'b1;
        end else if (stg_cnt_q == STG_LAST) begin
          ch_rst_n_d = (ch_rst_n_q << 1) | CH_FIRST;
        end else begin
          stg_cnt_d = stg_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        seq_done_d = 1'b1;
      end
      default: begin
        state_d    = S_PLL_RST;
        ch_rst_n_d = '0;
      end
    endcase

    // Lock loss drops the channels but leaves the PLL running.
    if (!lock_sync && (state_q inside {S_HOLD, S_RELEASE, S_RUN})) begin
      state_d    = S_WAIT_LOCK;
      ch_rst_n_d = '0;
      seq_done_d = 1'b0;
      hold_cnt_d = '0;
      stg_cnt_d  = '0;
      filt_cnt_d = '0;
    end

    // Button or software reset wins over everything and restarts the PLL pulse.
    if (!ext_rst_n_sync || sw_rst_i) begin
      state_d    = S_PLL_RST;
      pll_cnt_d  = '0;
      filt_cnt_d = '0;
      hold_cnt_d = '0;
      stg_cnt_d  = '0;
      ch_rst_n_d = '0;
      seq_done_d = 1'b0;
`ifdef SYS_RST_SEQ_TIMEOUT_EN
      to_cnt_d   = '0;
`endif
    end

    pll_rst_d = (state_d == S_PLL_RST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_PLL_RST;
      pll_cnt_q  <= '0;
      filt_cnt_q <= '0;
      hold_cnt_q <= '0;
      stg_cnt_q  <= '0;
      pll_rst_q  <= 1'b1;
      ch_rst_n_q <= '0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pll_cnt_q  <= pll_cnt_d;
      filt_cnt_q <= filt_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      stg_cnt_q  <= stg_cnt_d;
      pll_rst_q  <= pll_rst_d;
      ch_rst_n_q <= ch_rst_n_d;
      seq_done_q <= seq_done_d;
    end
  end

`ifdef SYS_RST_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign pll_rst_o  = pll_rst_q;
  assign ch_rst_n_o = ch_rst_n_q;
  assign seq_done_o = seq_done_q;

endmodule

// File: tb/tb_sys_rst_seq.sv
// Directed bench for sys_rst_seq: default instance plus a minimum-parameter instance.
// Edge numbers below count rising clock edges after the stimulus change (edge 1 = first).
module tb_sys_rst_seq;

  logic       clk_i;
  logic       rst_i;
  logic       ext_rst_n_i;
  logic       pll_locked_i;
  logic       sw_rst_i;
  logic       pll_rst_o;
  logic [3:0] ch_rst_n_o;
  logic       seq_done_o;
  logic       timeout_o;
  logic       m_pll_rst;
  logic [1:0] m_ch_rst_n;
  logic       m_seq_done;
  logic       m_timeout;

  int n_cmp = 0;
  int n_err = 0;

  sys_rst_seq dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ext_rst_n_i  (ext_rst_n_i),
    .pll_locked_i (pll_locked_i),
    .sw_rst_i     (sw_rst_i),
    .pll_rst_o    (pll_rst_o),
    .ch_rst_n_o   (ch_rst_n_o),
    .seq_done_o   (seq_done_o),
    .timeout_o    (timeout_o)
  );

  sys_rst_seq #(
    .NUM_CH      (2),
    .PLL_RST_CNT (1),
    .LOCK_FILTER (1),
    .HOLD_CNT    (0),
    .STAGGER_CNT (1)
  ) dut_min (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ext_rst_n_i  (ext_rst_n_i),
    .pll_locked_i (pll_locked_i),
    .sw_rst_i     (sw_rst_i),
    .pll_rst_o    (m_pll_rst),
    .ch_rst_n_o   (m_ch_rst_n),
    .seq_done_o   (m_seq_done),
    .timeout_o    (m_timeout)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; ext_rst_n_i = 1'b1; pll_locked_i = 1'b1; sw_rst_i = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    n_cmp++; if (pll_rst_o !== 1'b1) begin n_err++; $display("FAIL reset_pll: got %b want 1", pll_rst_o); end
    n_cmp++; if (ch_rst_n_o !== 4'h0) begin n_err++; $display("FAIL reset_ch: got %h want 0", ch_rst_n_o); end
    n_cmp++; if (seq_done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", seq_done_o); end
    n_cmp++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
    n_cmp++; if (m_pll_rst !== 1'b1 || m_ch_rst_n !== 2'b00) begin
      n_err++; $display("FAIL reset_min: got pll=%b ch=%b want pll=1 ch=00", m_pll_rst, m_ch_rst_n);
    end
    repeat (3) tick();
    n_cmp++; if (pll_rst_o !== 1'b1 || ch_rst_n_o !== 4'h0 || seq_done_o !== 1'b0) begin
      n_err++; $display("FAIL reset_held: got pll=%b ch=%h done=%b want 1/0/0", pll_rst_o, ch_rst_n_o, seq_done_o);
    end
  endtask

  // pll falls at 2 (sync) + 8, ch0 at +16 filter +50 hold, then 10-cycle stagger.
  task automatic test_cold_start();
    int pf = -1, c0 = -1, c1 = -1, c3 = -1, dn = -1;
    int mpf = -1, mc0 = -1, mc1 = -1, mdn = -1;
    logic [3:0] ch_at_c0 = 4'hx;
    rst_i = 1'b0;
    for (int e = 1; e <= 120; e++) begin
      tick();
      if (pf  < 0 && pll_rst_o === 1'b0)     pf  = e;
      if (c0  < 0 && ch_rst_n_o[0] === 1'b1) begin c0 = e; ch_at_c0 = ch_rst_n_o; end
      if (c1  < 0 && ch_rst_n_o[1] === 1'b1) c1  = e;
      if (c3  < 0 && ch_rst_n_o[3] === 1'b1) c3  = e;
      if (dn  < 0 && seq_done_o === 1'b1)    dn  = e;
      if (mpf < 0 && m_pll_rst === 1'b0)     mpf = e;
      if (mc0 < 0 && m_ch_rst_n[0] === 1'b1) mc0 = e;
      if (mc1 < 0 && m_ch_rst_n[1] === 1'b1) mc1 = e;
      if (mdn < 0 && m_seq_done === 1'b1)    mdn = e;
    end
    n_cmp++; if (pf  != 10)  begin n_err++; $display("FAIL cold_pll_fall: got edge %0d want 10", pf); end
    n_cmp++; if (c0  != 76)  begin n_err++; $display("FAIL cold_ch0: got edge %0d want 76", c0); end
    n_cmp++; if (ch_at_c0 !== 4'b0001) begin n_err++; $display("FAIL cold_ch0_only: got %b want 0001", ch_at_c0); end
    n_cmp++; if (c1  != 86)  begin n_err++; $display("FAIL cold_ch1: got edge %0d want 86", c1); end
    n_cmp++; if (c3  != 106) begin n_err++; $display("FAIL cold_ch3: got edge %0d want 106", c3); end
    n_cmp++; if (dn  != 107) begin n_err++; $display("FAIL cold_done: got edge %0d want 107", dn); end
    n_cmp++; if (ch_rst_n_o !== 4'hF || seq_done_o !== 1'b1 || timeout_o !== 1'b0) begin
      n_err++; $display("FAIL cold_run: got ch=%h done=%b to=%b want F/1/0", ch_rst_n_o, seq_done_o, timeout_o);
    end
    n_cmp++; if (mpf != 3) begin n_err++; $display("FAIL min_pll_fall: got edge %0d want 3", mpf); end
    n_cmp++; if (mc0 != 4) begin n_err++; $display("FAIL min_ch0: got edge %0d want 4", mc0); end
    n_cmp++; if (mc1 != 5) begin n_err++; $display("FAIL min_ch1: got edge %0d want 5", mc1); end
    n_cmp++; if (mdn != 6) begin n_err++; $display("FAIL min_done: got edge %0d want 6", mdn); end
  endtask

  // One-cycle lock drop: seen at edge 3, re-filter 16, hold 50 -> ch0 at 69.
  task automatic test_lock_glitch();
    int drop = -1, c0 = -1, dn = -1, pll_hi = 0, mc0 = -1;
    logic done_at_drop = 1'bx;
    pll_locked_i = 1'b0;
    for (int e = 1; e <= 110; e++) begin
      tick();
      if (e == 1) pll_locked_i = 1'b1;
      if (pll_rst_o !== 1'b0) pll_hi++;
      if (drop < 0 && ch_rst_n_o === 4'h0) begin drop = e; done_at_drop = seq_done_o; end
      if (drop >= 0 && c0 < 0 && ch_rst_n_o[0] === 1'b1) c0 = e;
      if (drop >= 0 && dn < 0 && seq_done_o === 1'b1) dn = e;
      if (drop >= 0 && mc0 < 0 && m_ch_rst_n[0] === 1'b1) mc0 = e;
    end
    n_cmp++; if (drop != 3) begin n_err++; $display("FAIL glitch_drop: got edge %0d want 3", drop); end
    n_cmp++; if (done_at_drop !== 1'b0) begin n_err++; $display("FAIL glitch_done_clr: got %b want 0", done_at_drop); end
    n_cmp++; if (pll_hi != 0) begin n_err++; $display("FAIL glitch_pll: got %0d high cycles want 0", pll_hi); end
    n_cmp++; if (c0 != 69) begin n_err++; $display("FAIL glitch_ch0: got edge %0d want 69", c0); end
    n_cmp++; if (dn != 100) begin n_err++; $display("FAIL glitch_done: got edge %0d want 100", dn); end
    n_cmp++; if (mc0 != 4) begin n_err++; $display("FAIL glitch_min_ch0: got edge %0d want 4", mc0); end
  endtask

  // Lock high for only 5 cycles at a time never satisfies a 16-cycle filter.
  task automatic test_lock_toggle();
    int bad_ch = 0, bad_done = 0, bad_pll = 0;
    for (int e = 1; e <= 200; e++) begin
      pll_locked_i = (((e - 1) / 5) % 2) == 1;
      tick();
      if (e >= 3 && ch_rst_n_o !== 4'h0) bad_ch++;
      if (e >= 3 && seq_done_o !== 1'b0) bad_done++;
      if (pll_rst_o !== 1'b0) bad_pll++;
    end
    pll_locked_i = 1'b1;
    n_cmp++; if (bad_ch != 0) begin n_err++; $display("FAIL toggle_ch: got %0d cycles released want 0", bad_ch); end
    n_cmp++; if (bad_done != 0) begin n_err++; $display("FAIL toggle_done: got %0d cycles done want 0", bad_done); end
    n_cmp++; if (bad_pll != 0) begin n_err++; $display("FAIL toggle_pll: got %0d cycles pll_rst want 0", bad_pll); end
  endtask

  // sw_rst and synced lock loss in the same cycle during release: sw_rst wins.
  task automatic test_sw_and_lock_loss();
    int found = 0, pf = -1, c0 = -1, dn = -1;
    for (int e = 1; e <= 200 && found == 0; e++) begin
      tick();
      if (ch_rst_n_o[0] === 1'b1 && seq_done_o === 1'b0) found = 1;
    end
    n_cmp++; if (found != 1) begin n_err++; $display("FAIL swlock_reach_release: got %0d want 1", found); end
    pll_locked_i = 1'b0;
    tick();
    tick();
    sw_rst_i = 1'b1;
    tick();
    sw_rst_i = 1'b0;
    pll_locked_i = 1'b1;
    n_cmp++; if (pll_rst_o !== 1'b1 || ch_rst_n_o !== 4'h0 || seq_done_o !== 1'b0) begin
      n_err++; $display("FAIL swlock_enter: got pll=%b ch=%h done=%b want 1/0/0", pll_rst_o, ch_rst_n_o, seq_done_o);
    end
    n_cmp++; if (m_pll_rst !== 1'b1) begin n_err++; $display("FAIL swlock_min_pll: got %b want 1", m_pll_rst); end
    for (int e = 4; e <= 120; e++) begin
      tick();
      if (pf < 0 && pll_rst_o === 1'b0) pf = e;
      if (c0 < 0 && ch_rst_n_o[0] === 1'b1) c0 = e;
      if (dn < 0 && seq_done_o === 1'b1) dn = e;
    end
    n_cmp++; if (pf != 11) begin n_err++; $display("FAIL swlock_pll_fall: got edge %0d want 11", pf); end
    n_cmp++; if (c0 != 77) begin n_err++; $display("FAIL swlock_ch0: got edge %0d want 77", c0); end
    n_cmp++; if (dn != 108) begin n_err++; $display("FAIL swlock_done: got edge %0d want 108", dn); end
  endtask

  // Button low 100 cycles: pll up at 3, down 100+8+2 = 110 after press.
  task automatic test_ext_rst();
    int pr = -1, pf = -1, c0 = -1, dn = -1;
    logic [3:0] ch_at_pr = 4'hx;
    ext_rst_n_i = 1'b0;
    for (int e = 1; e <= 210; e++) begin
      tick();
      if (e == 100) ext_rst_n_i = 1'b1;
      if (pr < 0 && pll_rst_o === 1'b1) begin pr = e; ch_at_pr = ch_rst_n_o; end
      if (pr >= 0 && pf < 0 && pll_rst_o === 1'b0) pf = e;
      if (pf >= 0 && c0 < 0 && ch_rst_n_o[0] === 1'b1) c0 = e;
      if (pf >= 0 && dn < 0 && seq_done_o === 1'b1) dn = e;
    end
    n_cmp++; if (pr != 3) begin n_err++; $display("FAIL ext_pll_rise: got edge %0d want 3", pr); end
    n_cmp++; if (ch_at_pr !== 4'h0) begin n_err++; $display("FAIL ext_ch_low: got %h want 0", ch_at_pr); end
    n_cmp++; if (pf != 110) begin n_err++; $display("FAIL ext_pll_fall: got edge %0d want 110", pf); end
    n_cmp++; if (c0 != 176) begin n_err++; $display("FAIL ext_ch0: got edge %0d want 176", c0); end
    n_cmp++; if (dn != 207) begin n_err++; $display("FAIL ext_done: got edge %0d want 207", dn); end
    // Asynchronous reset mid-run, checked before the next clock edge.
    tick();
    #3 rst_i = 1'b1;
    #1;
    n_cmp++; if (pll_rst_o !== 1'b1 || ch_rst_n_o !== 4'h0 || seq_done_o !== 1'b0 || timeout_o !== 1'b0) begin
      n_err++; $display("FAIL async_rst: got pll=%b ch=%h done=%b to=%b want 1/0/0/0",
                        pll_rst_o, ch_rst_n_o, seq_done_o, timeout_o);
    end
  endtask

  task automatic test_timeout();
    int pf1 = -1, pr2 = -1, pf2 = -1, tr = -1, to_clr = 0, to_hi = 0, ch_hi = 0;
    pll_locked_i = 1'b0;
    tick();
    rst_i = 1'b0;
`ifdef SYS_RST_SEQ_TIMEOUT_EN
    // Wait-lock entered at edge 10; timeout at its 1000th cycle = edge 1010.
    for (int e = 1; e <= 1160; e++) begin
      tick();
      if (e == 1050) pll_locked_i = 1'b1;
      if (pf1 < 0 && pll_rst_o === 1'b0) pf1 = e;
      if (pf1 >= 0 && pr2 < 0 && pll_rst_o === 1'b1) pr2 = e;
      if (pr2 >= 0 && pf2 < 0 && pll_rst_o === 1'b0) pf2 = e;
      if (tr < 0 && timeout_o === 1'b1) tr = e;
      if (tr >= 0 && timeout_o !== 1'b1) to_clr++;
    end
    n_cmp++; if (pf1 != 10) begin n_err++; $display("FAIL to_pll_fall: got edge %0d want 10", pf1); end
    n_cmp++; if (tr != 1010) begin n_err++; $display("FAIL to_set: got edge %0d want 1010", tr); end
    n_cmp++; if (pr2 != 1010) begin n_err++; $display("FAIL to_pll_repulse: got edge %0d want 1010", pr2); end
    n_cmp++; if (pf2 != 1018) begin n_err++; $display("FAIL to_pll_fall2: got edge %0d want 1018", pf2); end
    n_cmp++; if (to_clr != 0) begin n_err++; $display("FAIL to_sticky: got %0d cleared cycles want 0", to_clr); end
    n_cmp++; if (seq_done_o !== 1'b1 || timeout_o !== 1'b1) begin
      n_err++; $display("FAIL to_after_lock: got done=%b to=%b want 1/1", seq_done_o, timeout_o);
    end
`else
    // Without the timeout the sequencer waits for lock indefinitely.
    for (int e = 1; e <= 1100; e++) begin
      tick();
      if (pf1 < 0 && pll_rst_o === 1'b0) pf1 = e;
      if (pf1 >= 0 && pll_rst_o !== 1'b0) pr2 = e;
      if (timeout_o !== 1'b0) to_hi++;
      if (ch_rst_n_o !== 4'h0) ch_hi++;
    end
    n_cmp++; if (pf1 != 10) begin n_err++; $display("FAIL nto_pll_fall: got edge %0d want 10", pf1); end
    n_cmp++; if (pr2 != -1) begin n_err++; $display("FAIL nto_no_repulse: got edge %0d want none (-1)", pr2); end
    n_cmp++; if (to_hi != 0) begin n_err++; $display("FAIL nto_timeout: got %0d cycles set want 0", to_hi); end
    n_cmp++; if (ch_hi != 0) begin n_err++; $display("FAIL nto_ch: got %0d cycles released want 0", ch_hi); end
`endif
    pll_locked_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_lock_glitch();
    test_lock_toggle();
    test_sw_and_lock_loss();
    test_ext_rst();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
